gray_monitor: RTL and testbench

GRAY_MONITOR -- requirements
Module: gray_monitor

---
 rtl/gray_monitor.sv | 89 ++++++++
 tb/tb_gray_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_monitor.sv
// gray_monitor: checks an up-counting 3-bit Gray stream, decodes it, and counts legal wraps
module gray_monitor (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [2:0] i_gray_in,
    input  logic       i_clear,
    output logic [2:0] o_output,
    output logic       o_overflow,
    output logic       o_locked,
    output logic       o_error,
    output logic [7:0] o_wrap_count
);
    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_LOCKED   = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_ref, w_ref_nxt;
    logic [2:0] r_out, w_out_nxt;
    logic       r_ovf, w_ovf_nxt;
    logic [7:0] r_wrap, w_wrap_nxt;
    logic [2:0] w_bin;
    logic       w_step;
    logic       w_wrap;

    assign w_bin  = {i_gray_in[2], ^i_gray_in[2:1], ^i_gray_in};
    assign w_step = w_bin == r_out + 3'd1;
    assign w_wrap = w_bin == 3'd0;

    // State register and all registered outputs; reset forces everything to zero at once
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_UNLOCKED;
            r_ref   <= '0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_wrap  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ref   <= w_ref_nxt;
            r_out   <= w_out_nxt;
            r_ovf   <= w_ovf_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // Next-state logic: Clear beats En; in LOCKED only a repeat or a +1 step is legal
    always_comb begin
        w_state_nxt = r_state;
        w_ref_nxt   = r_ref;
        w_out_nxt   = r_out;
        w_ovf_nxt   = 1'b0;
        w_wrap_nxt  = r_wrap;
        if (i_clear) begin
            w_state_nxt = S_UNLOCKED;
            w_wrap_nxt  = '0;
        end else if (i_en) begin
            case (r_state)
                S_UNLOCKED: begin
                    w_state_nxt = S_LOCKED;
                    w_ref_nxt   = i_gray_in;
                    w_out_nxt   = w_bin;
                end
                S_LOCKED: begin
                    if (i_gray_in != r_ref) begin
                        if (w_step) begin
                            w_ref_nxt  = i_gray_in;
                            w_out_nxt  = w_bin;
                            w_ovf_nxt  = w_wrap;
                            w_wrap_nxt = (w_wrap && r_wrap != 8'hff) ? r_wrap + 8'd1 : r_wrap;
                        end else begin
                            w_state_nxt = S_ERROR;
                        end
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign o_output     = r_out;
    assign o_overflow   = r_ovf;
    assign o_locked     = r_state == S_LOCKED;
    assign o_error      = r_state == S_ERROR;
    assign o_wrap_count = r_wrap;
endmodule

// File: tb/tb_gray_monitor.sv
// tb_gray_monitor: randomized and directed checks of gray_monitor against a behavioural model
module tb_gray_monitor;
    logic       clk, rst_n, en, clr;
    logic [2:0] gray;
    logic [2:0] out;
    logic       ovf, locked, err;
    logic [7:0] wrap;
    int         checks = 0;
    int         errors = 0;

    int         m_state;
    logic [2:0] m_ref;
    logic [2:0] m_out;
    logic       m_ovf;
    logic [7:0] m_wrap;

    gray_monitor dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_gray_in(gray), .i_clear(clr),
        .o_output(out), .o_overflow(ovf), .o_locked(locked), .o_error(err), .o_wrap_count(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] to_gray(input int b);
        return 3'((b % 8) ^ ((b % 8) >> 1));
    endfunction

    function automatic int to_bin(input logic [2:0] g);
        int v = int'(g);
        return (v ^ (v >> 1) ^ (v >> 2)) % 8;
    endfunction

    function automatic logic [13:0] obs();
        return {out, ovf, locked, err, wrap};
    endfunction

    function automatic logic [13:0] expv();
        return {m_out, m_ovf, m_state == 1, m_state == 2, m_wrap};
    endfunction

    task automatic model_reset();
        m_state = 0; m_ref = 0; m_out = 0; m_ovf = 0; m_wrap = 0;
    endtask

    task automatic model_clk(input logic e, input logic c, input logic [2:0] g);
        int b = to_bin(g);
        m_ovf = 0;
        if (c) begin
            m_state = 0;
            m_wrap  = 0;
        end else if (e) begin
            if (m_state == 0) begin
                m_state = 1; m_ref = 3'(b); m_out = 3'(b);
            end else if (m_state == 1 && b != int'(m_ref)) begin
                if (b == (int'(m_ref) + 1) % 8) begin
                    m_ref = 3'(b); m_out = 3'(b);
                    if (b == 0) begin
                        m_ovf = 1;
                        if (m_wrap < 255) m_wrap = m_wrap + 1;
                    end
                end else begin
                    m_state = 2;
                end
            end
        end
    endtask

    task automatic step(input logic e, input logic c, input logic [2:0] g);
        @(negedge clk);
        en = e; clr = c; gray = g;
        @(posedge clk);
        model_clk(e, c, g);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; clr = 0; gray = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        if (obs() !== expv()) begin errors++; $display("FAIL reset got %h exp %h", obs(), expv()); end
        checks++;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        if (obs() !== 14'h0) begin errors++; $display("FAIL reset_idle got %h exp %h", obs(), 14'h0); end
        checks++;
    endtask

    task automatic test_stream();
        logic [2:0] codes [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        step(0, 1, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 0, codes[i]);
            if (obs() !== expv()) begin errors++; $display("FAIL stream step %0d got %h exp %h", i, obs(), expv()); end
            checks++;
            if (out !== 3'(i % 8)) begin errors++; $display("FAIL stream_out step %0d got %0d exp %0d", i, out, i % 8); end
            checks++;
        end
        if ({ovf, wrap, err} !== {1'b1, 8'd1, 1'b0}) begin errors++; $display("FAIL stream_wrap got ovf=%b wrap=%0d err=%b exp 1 1 0", ovf, wrap, err); end
        checks++;
        step(0, 0, 0);
        if (ovf !== 1'b0) begin errors++; $display("FAIL stream_pulse got %b exp 0", ovf); end
        checks++;
    endtask

    task automatic test_hold_gaps();
        step(0, 1, 0);
        step(1, 0, 3'b011);
        step(1, 0, 3'b011);
        step(0, 0, 3'b110);
        step(0, 0, 3'b111);
        step(1, 0, 3'b011);
        if (obs() !== expv() || out !== 3'd2) begin errors++; $display("FAIL hold got %h exp %h", obs(), expv()); end
        checks++;
        step(1, 0, 3'b010);
        if (obs() !== expv() || out !== 3'd3 || err !== 1'b0) begin errors++; $display("FAIL hold_step got %h exp %h", obs(), expv()); end
        checks++;
    endtask

    task automatic test_jump_error();
        step(0, 1, 0);
        step(1, 0, 3'b001);
        step(1, 0, 3'b010);
        if (obs() !== expv() || {err, locked, out} !== {1'b1, 1'b0, 3'd1}) begin errors++; $display("FAIL jump got %h exp %h", obs(), expv()); end
        checks++;
        step(1, 0, 3'b011);
        if (obs() !== expv() || out !== 3'd1 || err !== 1'b1) begin errors++; $display("FAIL jump_sticky got %h exp %h", obs(), expv()); end
        checks++;
    endtask

    task automatic test_backward_clear();
        step(0, 1, 0);
        step(1, 0, 3'b011);
        step(1, 0, 3'b001);
        if (obs() !== expv() || err !== 1'b1) begin errors++; $display("FAIL back got %h exp %h", obs(), expv()); end
        checks++;
        step(1, 1, 3'b110);
        if (obs() !== expv() || {err, locked, out} !== {1'b0, 1'b0, 3'd2}) begin errors++; $display("FAIL back_clear got %h exp %h", obs(), expv()); end
        checks++;
        step(1, 0, 3'b110);
        if (obs() !== expv() || {locked, out} !== {1'b1, 3'd4}) begin errors++; $display("FAIL back_relock got %h exp %h", obs(), expv()); end
        checks++;
    endtask

    task automatic test_saturate();
        int pulses = 0;
        step(0, 1, 0);
        step(1, 0, 3'b000);
        for (int i = 1; i <= 260 * 8; i++) begin
            step(1, 0, to_gray(i));
            if (ovf === 1'b1) pulses++;
            if (obs() !== expv()) begin errors++; $display("FAIL sat step %0d got %h exp %h", i, obs(), expv()); end
            checks++;
        end
        if (wrap !== 8'd255 || pulses != 260) begin errors++; $display("FAIL sat_final got wrap=%0d pulses=%0d exp 255 260", wrap, pulses); end
        checks++;
    endtask

    task automatic test_async_reset();
        step(0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 0, to_gray(i));
        @(negedge clk);
        en = 1; gray = 3'b000;
        #2 rst_n = 0;
        #1;
        model_reset();
        if (obs() !== expv()) begin errors++; $display("FAIL areset got %h exp %h", obs(), expv()); end
        checks++;
        @(posedge clk); #1;
        if (obs() !== 14'h0) begin errors++; $display("FAIL areset_hold got %h exp %h", obs(), 14'h0); end
        checks++;
        @(negedge clk);
        rst_n = 1; en = 0;
        step(1, 0, 3'b011);
        if (obs() !== expv() || {locked, out, ovf} !== {1'b1, 3'd2, 1'b0}) begin errors++; $display("FAIL areset_relock got %h exp %h", obs(), expv()); end
        checks++;
    endtask

    task automatic test_random();
        logic       e, c;
        logic [2:0] g;
        int         r;
        step(0, 1, 0);
        for (int i = 0; i < 600; i++) begin
            e = ($urandom % 4) != 0;
            c = ($urandom % 25) == 0;
            r = $urandom % 20;
            g = r < 14 ? to_gray(int'(m_ref) + 1) : r < 17 ? m_ref : 3'($urandom);
            step(e, c, g);
            if (obs() !== expv()) begin errors++; $display("FAIL random step %0d got %h exp %h", i, obs(), expv()); end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold_gaps();
        test_jump_error();
        test_backward_clear();
        test_saturate();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
